pulse_stretch: RTL
==================

# pulse_stretch

Inverse of the single-cycle edge pulser: converts each single-cycle strobe into an output pulse exactly HIGH_CYCLES clocks wide, followed by a mandatory low gap of GAP_CYCLES clocks. It sits on the SPI side of the design, where it drives slow consumers such as LEDs, scope triggers and reset lines from one-cycle events. Strobes arriving while a pulse is in progress are either dropped or counted and replayed, depending on build configuration.

## Interface
- HIGH_CYCLES, 8, output high width in clocks; legal range ≥1
- GAP_CYCLES, 2, minimum low time between output pulses; legal range ≥1
- QUEUE_MAX, 3, pending-event saturation limit; legal range ≥1; used only with the queue feature
- clk  input  1  clock
- reset  input  1  reset: synchronous, active-high
- in  input  1  event strobe; every cycle sampled high counts as one event
- out  output  1  stretched pulse, registered
- busy  output  1  high while in HIGH or GAP
- dropped  output  1  one-cycle flag; an event was discarded
- pending  output  $clog2(QUEUE_MAX+1)  queued events not yet replayed; tied 0 when the queue feature is compiled out

## Operation
- States: IDLE, HIGH, GAP. Down-counter `cnt`, width $clog2(max(HIGH_CYCLES,GAP_CYCLES)+1).
- Reset values: state=IDLE, cnt=0, out=0, busy=0, dropped=0, pending=0. Reset has priority over all other events, including mid-pulse.
- IDLE, in=1:
  - next state HIGH, cnt=HIGH_CYCLES-1.
- HIGH:
  - cnt==0 → next state GAP, cnt=GAP_CYCLES-1.
  - otherwise cnt decrements.
- GAP, cnt==0:
  - If pending>0 → next state HIGH, cnt=HIGH_CYCLES-1, pending decrements.
  - Else, if in=1 with queue enabled → next state HIGH directly; pending unchanged.
  - Otherwise → next state IDLE.
- GAP, cnt≠0:
  - cnt decrements.
- in=1 while in HIGH or GAP (other than the GAP-exit consumption case above):
  - Queue enabled, pending<QUEUE_MAX → pending+1.
  - Queue enabled, pending==QUEUE_MAX → pending holds; dropped=1 next cycle.
  - Queue disabled → dropped=1 next cycle.
- Pending increment and decrement in the same cycle → net pending unchanged; the event is not dropped.
- Output decode:
  - out=1 iff state==HIGH.
  - busy=1 iff state≠IDLE.
  - Both are registered alongside state; no combinational path from in.

## Timing
- Strobe sampled at edge t in IDLE → out=1 for cycles t+1 through t+HIGH_CYCLES.
- out=0 for cycles t+HIGH_CYCLES+1 through t+HIGH_CYCLES+GAP_CYCLES.
- A replayed event raises out at cycle t+HIGH_CYCLES+GAP_CYCLES+1. Back-to-back pulses therefore repeat with period HIGH_CYCLES+GAP_CYCLES.
- dropped asserts one cycle after the offending strobe and lasts exactly 1 cycle.
- in held high for N cycles counts as N events. No edge detection is performed; upstream supplies strobes.

## Configuration
- Macro: PULSE_STRETCH_QUEUE_EN.
- Defined:
  - Pending counter is present, saturates at QUEUE_MAX.
  - Queued events are replayed after each gap.
  - An in=1 on the last GAP cycle chains directly into HIGH.
- Undefined:
  - No counter; pending=0 constant.
  - Every in=1 outside IDLE is dropped with dropped=1.
  - Outside IDLE, in has no effect on state.

## Structure
- Shared package `pulse_pkg`: state enum `stretch_state_t` (IDLE/HIGH/GAP), plus a helper function for counter width.
- A single module is required. The saturating up/down pending counter is a natural sub-module, `sat_updown_counter`, instantiated only under PULSE_STRETCH_QUEUE_EN.
- Formal properties are guarded by the existing formal define:
  - out never high for more than HIGH_CYCLES consecutive cycles.
  - Low gap between output pulses is never shorter than GAP_CYCLES.
  - pending never exceeds QUEUE_MAX.

## Test plan
- HIGH=4, GAP=2, single strobe at cycle 0 → out=1 cycles 1–4, busy=1 cycles 1–6, idle from cycle 7, dropped never asserted.
- Queue enabled, strobes at cycles 0 and 2 → out=1 cycles 1–4 and 7–10; pending=1 cycles 3–6, then 0.
- Queue disabled, strobes at cycles 0 and 2 → out=1 cycles 1–4 only; dropped=1 at cycle 3.
- Queue enabled, QUEUE_MAX=3, in held high cycles 0–4 → pending saturates at 3 by cycle 4, dropped=1 at cycle 5, followed by four output pulses total.
- Reset asserted at cycle 2 of a pulse with pending=2 → cycle 3: out=0, busy=0, pending=0; the next strobe behaves as if from IDLE.
- Queue enabled, strobe on the last GAP cycle with pending=0 → out rises on the next cycle, with no IDLE cycle in between.

Source files
------------

// File: rtl/pulse_pkg.sv
// ---------------------------------------------------------------------------
// pulse_pkg
// Shared types and helpers for the pulse stretcher.
//   stretch_state_t : IDLE / HIGH / GAP sequencing of one output pulse
//   cnt_width()     : bit width of the down-counter that times both the
//                     HIGH and GAP phases (must hold the larger of the two)
// ---------------------------------------------------------------------------
package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } stretch_state_t;

  // One counter is reused for both phases, so it is sized for the longer one.
  function automatic int cnt_width(input int high_cycles, input int gap_cycles);
    int longest;
    longest = (high_cycles > gap_cycles) ? high_cycles : gap_cycles;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/sat_updown_counter.sv
// ---------------------------------------------------------------------------
// sat_updown_counter
// Up/down counter that saturates at MAX_COUNT and never wraps below zero.
// Holds the number of strobes waiting to be replayed by the pulse stretcher.
//
// Ports:
//   clk      in   clock
//   reset    in   synchronous, active-high reset (count -> 0)
//   inc      in   add one (ignored when already at MAX_COUNT, unless dec)
//   dec      in   remove one (ignored when already zero, unless inc)
//   count    out  current count
//   full     out  count == MAX_COUNT
//   nonzero  out  count != 0
// ---------------------------------------------------------------------------
module sat_updown_counter
  import pulse_pkg::*;
#(
  parameter int MAX_COUNT = 3,
  parameter int W         = $clog2(MAX_COUNT + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full,
  output logic         nonzero
);

  localparam logic [W-1:0] MAX_VAL = W'(MAX_COUNT);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Simultaneous inc and dec cancel, so a full counter can still accept a
  // new event in the same cycle one is consumed.
  always_comb begin
    count_d = count_q;
    if (inc && !dec && (count_q != MAX_VAL)) begin
      count_d = count_q + W'(1);
    end else if (dec && !inc && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign full    = (count_q == MAX_VAL);
  assign nonzero = (count_q != '0);

endmodule

// File: rtl/pulse_stretch.sv
// ---------------------------------------------------------------------------
// pulse_stretch
// Turns each one-cycle strobe into an output pulse exactly HIGH_CYCLES wide,
// followed by at least GAP_CYCLES low cycles. Strobes that arrive while a
// pulse (or its gap) is in progress are either dropped, or - when the
// PULSE_STRETCH_QUEUE_EN macro is defined - counted and replayed back to
// back after each gap.
//
// Parameters:
//   HIGH_CYCLES  output high width in clocks (>=1)
//   GAP_CYCLES   minimum low time between pulses (>=1)
//   QUEUE_MAX    saturation limit of the pending-event counter (>=1)
//
// Ports:
//   clk      in   clock
//   reset    in   synchronous, active-high reset
//   in       in   event strobe; each high cycle is one event
//   out      out  stretched pulse (registered)
//   busy     out  high while in HIGH or GAP (registered)
//   dropped  out  one-cycle flag: an event was discarded
//   pending  out  events queued for replay (0 without the queue feature)
//
// Build option: PULSE_STRETCH_QUEUE_EN enables the pending-event queue.
// Formal properties are compiled under FORMAL.
// ---------------------------------------------------------------------------
module pulse_stretch
  import pulse_pkg::*;
#(
  parameter int HIGH_CYCLES = 8,
  parameter int GAP_CYCLES  = 2,
  parameter int QUEUE_MAX   = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in,
  output logic                           out,
  output logic                           busy,
  output logic                           dropped,
  output logic [$clog2(QUEUE_MAX+1)-1:0] pending
);

  localparam int CW = cnt_width(HIGH_CYCLES, GAP_CYCLES);
  localparam int PW = $clog2(QUEUE_MAX + 1);

  // The counter is loaded with N-1 so a phase lasts exactly N cycles
  // including the cycle in which cnt reaches zero.
  localparam logic [CW-1:0] HIGH_LOAD = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

  stretch_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           out_q, out_d;
  logic           busy_q, busy_d;
  logic           dropped_q, dropped_d;

  // A strobe seen while a pulse is already in flight and not used to start
  // the next pulse directly; it must be queued or dropped.
  logic           stray_event;

`ifdef PULSE_STRETCH_QUEUE_EN
  logic           q_inc;
  logic           q_dec;
  logic           q_full;
  logic           q_nonzero;
  logic [PW-1:0]  q_count;

  sat_updown_counter #(
    .MAX_COUNT (QUEUE_MAX),
    .W         (PW)
  ) u_pending (
    .clk     (clk),
    .reset   (reset),
    .inc     (q_inc),
    .dec     (q_dec),
    .count   (q_count),
    .full    (q_full),
    .nonzero (q_nonzero)
  );
`endif

  // Next-state logic. At the last GAP cycle, a queued event takes
  // precedence over a fresh strobe; the fresh strobe then goes into the
  // queue in place of the one being replayed.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stray_event = 1'b0;
    dropped_d   = 1'b0;
`ifdef PULSE_STRETCH_QUEUE_EN
    q_inc       = 1'b0;
    q_dec       = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (in) begin
          state_d = HIGH;
          cnt_d   = HIGH_LOAD;
        end
      end

      HIGH: begin
        stray_event = in;
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      GAP: begin
        if (cnt_q == '0) begin
`ifdef PULSE_STRETCH_QUEUE_EN
          if (q_nonzero) begin
            state_d     = HIGH;
            cnt_d       = HIGH_LOAD;
            q_dec       = 1'b1;
            stray_event = in;
          end else if (in) begin
            state_d = HIGH;
            cnt_d   = HIGH_LOAD;
          end else begin
            state_d = IDLE;
          end
`else
          state_d     = IDLE;
          stray_event = in;
`endif
        end else begin
          cnt_d       = cnt_q - CW'(1);
          stray_event = in;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A full queue can still take an event in the cycle one is replayed,
    // because the increment and decrement cancel.
`ifdef PULSE_STRETCH_QUEUE_EN
    if (stray_event) begin
      if (!q_full || q_dec) begin
        q_inc = 1'b1;
      end else begin
        dropped_d = 1'b1;
      end
    end
`else
    dropped_d = stray_event;
`endif

    out_d  = (state_d == HIGH);
    busy_d = (state_d != IDLE);
  end

  // State, timer and decoded outputs all register together so out/busy
  // carry no combinational path from in.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      out_q     <= 1'b0;
      busy_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      busy_q    <= busy_d;
      dropped_q <= dropped_d;
    end
  end

  assign out     = out_q;
  assign busy    = busy_q;
  assign dropped = dropped_q;

`ifdef PULSE_STRETCH_QUEUE_EN
  assign pending = q_count;
`else
  assign pending = '0;
`endif

`ifdef FORMAL
  // Run-length trackers: consecutive high cycles before the current one,
  // and consecutive low cycles before the current one.
  int unsigned f_high_run;
  int unsigned f_low_run;
  logic        f_seen_pulse;

  always_ff @(posedge clk) begin
    if (reset) begin
      f_high_run   <= 0;
      f_low_run    <= 0;
      f_seen_pulse <= 1'b0;
    end else if (out_q) begin
      f_high_run   <= f_high_run + 1;
      f_low_run    <= 0;
      f_seen_pulse <= 1'b1;
    end else begin
      f_high_run   <= 0;
      f_low_run    <= f_low_run + 1;
    end
  end

  a_high_width : assert property (@(posedge clk) disable iff (reset)
    !(out_q && (f_high_run >= HIGH_CYCLES)));

  a_min_gap : assert property (@(posedge clk) disable iff (reset)
    (out_q && (f_high_run == 0) && f_seen_pulse) |-> (f_low_run >= GAP_CYCLES));

  a_pending_max : assert property (@(posedge clk) disable iff (reset)
    (int'(pending) <= QUEUE_MAX));
`endif

endmodule
